spi_slave_rx: RTL and testbench
===============================

// Module: spi_slave_rx
// PURPOSE
// - SPI slave receiver: the device-side end of the DAC SPI link (spi_clk, spi_cs_n, mosi).
// - Oversamples the asynchronous SPI pins in the s_clk domain and deserializes one frame per cs_n window.
// - Presents the received word with a one-cycle strobe and flags malformed frames.
// - Serves as the loopback checker / DAC model for the SPI master and as the receive path for slave-mode boards.
// PARAMETERS
// - FRAME_BITS   16   bits per frame (cs_n low window); legal range 2..32
// - MSB_FIRST    1    1: first bit lands in rx_data[FRAME_BITS-1]; 0: first bit lands in rx_data[0]
// - SYNC_STAGES  2    synchronizer depth for spi_clk, spi_cs_n, mosi; must be >= 2
// PORTS
// - s_clk      in   1           system clock; all logic on rising edge
// - s_rst      in   1           synchronous reset, active-high
// - spi_clk    in   1           SPI clock, async to s_clk; mode 0 (idle low, sample on rising edge)
// - spi_cs_n   in   1           chip select, async, active-low, frames the transfer
// - mosi       in   1           serial data, async, valid around spi_clk rising edge
// - rx_data    out  FRAME_BITS  last good frame; holds until the next good frame
// - rx_valid   out  1           1-cycle strobe: rx_data updated this cycle
// - frame_err  out  1           1-cycle strobe: frame ended with bit count != FRAME_BITS
// - busy       out  1           high while in SHIFT state
// BEHAVIOUR
// - Clock/reset: single domain s_clk; synchronous, active-high s_rst.
// - Reset values: rx_data=0, rx_valid=0, frame_err=0, busy=0, state=ARM, shift reg and bit count = 0.
// - Inputs pass SYNC_STAGES flops, then one edge-detect flop; all three pins share identical delay.
// - Timing req on master: spi_clk high and low >= 3 s_clk each; cs_n high between frames >= 3 s_clk.
// - FSM states: ARM, IDLE, SHIFT.
//   - ARM: wait for synced cs_n=1 -> IDLE. Entered after reset so a frame already in progress is never captured.
//   - IDLE: synced cs_n falling edge -> SHIFT; clear bit count and shift reg.
//   - SHIFT: on each synced spi_clk rising edge, shift in synced mosi and increment bit count.
//     Bit count saturates at FRAME_BITS+1, width $clog2(FRAME_BITS+2).
//   - SHIFT exit: synced cs_n rising edge -> IDLE.
//     - count == FRAME_BITS: rx_data <= shift reg, rx_valid=1.
//     - otherwise (short, long or zero-bit frame): frame_err=1, rx_data unchanged.
// - Edge coincidence rules:
//   - spi_clk rising edge in the same sync cycle as cs_n falling: ignored (not counted).
//   - spi_clk rising edge in the same sync cycle as cs_n rising: ignored.
// - Latency: pin cs_n rise -> rx_valid/frame_err high exactly SYNC_STAGES+1 s_clk later.
// - rx_valid and frame_err are never high in the same cycle; each is exactly one cycle wide.
// - busy follows state==SHIFT.
// - s_rst mid-frame: outputs cleared next edge, state ARM; the remaining bits of that frame are discarded, no strobes.
// - Glitch-free operation is guaranteed only within the timing requirements above; spi_clk edges outside SHIFT are ignored.
// STRUCTURE
// - Shared include spi_defs.vh: DAC_FRAME_BITS (16), state encodings ST_ARM/ST_IDLE/ST_SHIFT, SPI mode constants;
//   also used by the SPI master.
// - Sub-module sync_edge (SYNC_STAGES flop synchronizer + rise/fall pulse outputs):
//   3 instances, for spi_clk, spi_cs_n and mosi (mosi uses the level output only).
// - Top level holds the FSM, shift register, bit counter and output registers.
// TESTING
// - Reset: hold s_rst 3 cycles -> all outputs 0, busy 0; release with cs_n high -> FSM in IDLE within 3 cycles.
// - Good frame: send 0xA5C3 MSB first, spi_clk period 8 s_clk -> rx_data=0xA5C3, rx_valid one cycle,
//   3 cycles after cs_n rises.
// - Bad frame lengths, each -> frame_err one cycle, rx_valid 0, rx_data keeps the previous good value:
//   - short: 15 bits;
//   - long: 17 bits;
//   - zero bits: cs_n low 10 cycles.
// - Back-to-back frames: 0x0000 then 0xFFFF, cs_n high 3 s_clk between -> two rx_valid pulses, data in order.
// - Reset mid-frame: assert s_rst after 7 bits, release with cs_n still low ->
//   no strobe for that frame; next full frame 0x1234 -> received correctly.
// - Loopback: connect the DAC SPI master top outputs to the pins, drive codes 0x0000, 0x3FF0, 0xFFFC ->
//   each rx_data equals the word the master shifted out.

Source files
------------

// File: rtl/spi_slave_rx_pkg.sv
// Shared SPI definitions: DAC frame size, receiver FSM states, SPI mode.
// Imported by the receiver and usable by the SPI master side.
package spi_slave_rx_pkg;

    localparam int DAC_FRAME_BITS = 16;

    // SPI mode 0: clock idles low, data sampled on the rising edge
    localparam bit SPI_CPOL = 1'b0;
    localparam bit SPI_CPHA = 1'b0;

    typedef enum logic [1:0] {
        ST_ARM   = 2'd0,
        ST_IDLE  = 2'd1,
        ST_SHIFT = 2'd2
    } state_e;

endpackage

// File: rtl/spi_slave_rx_sync_edge.sv
// Multi-flop synchronizer for one asynchronous pin plus edge pulses.
// Ports: clk_i, rst_i (sync, active-high), d_i (async pin),
//        level_o (synced level), rise_o / fall_o (1-cycle edge pulses).
module spi_slave_rx_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_o  = sync_q[STAGES-1] & ~prev_q;
    assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_slave_rx.sv
// SPI slave receiver: oversamples spi_clk/spi_cs_n/mosi in s_clk, one frame per cs_n window.
// Ports: s_clk, s_rst (sync, active-high), spi_clk, spi_cs_n, mosi (async pins);
//        rx_data (last good frame), rx_valid / frame_err (1-cycle strobes), busy (in SHIFT).
module spi_slave_rx
    import spi_slave_rx_pkg::*;
#(
    parameter int FRAME_BITS  = DAC_FRAME_BITS,
    parameter bit MSB_FIRST   = 1'b1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  s_clk,
    input  logic                  s_rst,
    input  logic                  spi_clk,
    input  logic                  spi_cs_n,
    input  logic                  mosi,
    output logic [FRAME_BITS-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  frame_err,
    output logic                  busy
);

    localparam int CW = $clog2(FRAME_BITS + 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(FRAME_BITS);
    localparam logic [CW-1:0] CNT_SAT  = CW'(FRAME_BITS + 1);
    localparam bit SAMPLE_RISE = (SPI_CPOL == SPI_CPHA);

    logic sck_lvl, sck_rise, sck_fall;
    logic cs_lvl, cs_rise, cs_fall;
    logic mosi_lvl, mosi_rise, mosi_fall;
    logic sck_edge;
    logic unused_mosi_edges;

    state_e                state_q, state_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [FRAME_BITS-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  err_q, err_d;

    spi_slave_rx_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sck (
        .clk_i(s_clk), .rst_i(s_rst), .d_i(spi_clk),
        .level_o(sck_lvl), .rise_o(sck_rise), .fall_o(sck_fall)
    );

    spi_slave_rx_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_cs (
        .clk_i(s_clk), .rst_i(s_rst), .d_i(spi_cs_n),
        .level_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall)
    );

    spi_slave_rx_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk_i(s_clk), .rst_i(s_rst), .d_i(mosi),
        .level_o(mosi_lvl), .rise_o(mosi_rise), .fall_o(mosi_fall)
    );

    // mosi is only ever sampled as a level, aligned with the clock edge pulse
    assign unused_mosi_edges = mosi_rise ^ mosi_fall ^ sck_lvl;

    assign sck_edge = SAMPLE_RISE ? sck_rise : sck_fall;

    function automatic logic [FRAME_BITS-1:0] shift_in(
        input logic [FRAME_BITS-1:0] sr,
        input logic                  b
    );
        if (MSB_FIRST) return {sr[FRAME_BITS-2:0], b};
        else           return {b, sr[FRAME_BITS-1:1]};
    endfunction

    always_ff @(posedge s_clk) begin
        if (s_rst) begin
            state_q <= ST_ARM;
            shift_q <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    // ARM only releases once cs_n is seen high, so a frame already
    // running at reset release is never partially captured.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_ARM:   if (cs_lvl)  state_d = ST_IDLE;
            ST_IDLE:  if (cs_fall) state_d = ST_SHIFT;
            ST_SHIFT: if (cs_rise) state_d = ST_IDLE;
            default:               state_d = ST_ARM;
        endcase
    end

    // cs_n edges take priority, so a coincident clock edge is dropped.
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    shift_d = '0;
                    cnt_d   = '0;
                end
            end
            ST_SHIFT: begin
                if (cs_rise) begin
                    if (cnt_q == CNT_FULL) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (sck_edge) begin
                    shift_d = shift_in(shift_q, mosi_lvl);
                    if (cnt_q != CNT_SAT) cnt_d = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = err_q;
    assign busy      = (state_q == ST_SHIFT);

endmodule

// File: tb/tb_spi_slave_rx.sv
// Randomized self-checking bench for spi_slave_rx.
// A pin-level SPI master drives frames; a bit-queue model predicts strobes.
module tb_spi_slave_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sck = 1'b0;
    logic        csn = 1'b1;
    logic        sdi = 1'b0;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        frame_err;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        bit          ok;
        logic [15:0] data;
        int          cyc;
    } ev_t;

    ev_t         ev_q[$];
    ev_t         exp_q[$];
    bit          sent_q[$];
    logic [15:0] last_good = 16'h0000;

    always #5 clk = ~clk;

    spi_slave_rx dut (
        .s_clk    (clk),
        .s_rst    (rst),
        .spi_clk  (sck),
        .spi_cs_n (csn),
        .mosi     (sdi),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .frame_err(frame_err),
        .busy     (busy)
    );

    // Record every strobe cycle; one strobe cycle per frame is expected.
    always @(posedge clk) begin
        cyc++;
        #1;
        if (rx_valid === 1'b1 || frame_err === 1'b1) begin
            checks++;
            if (rx_valid === 1'b1 && frame_err === 1'b1) begin
                errors++;
                $display("FAIL strobe_excl: rx_valid=%b frame_err=%b, required not both",
                         rx_valid, frame_err);
            end
            ev_q.push_back('{rx_valid, rx_data, cyc});
        end
    end

    task automatic clk_bit(input bit b, input int half);
        sdi = b;
        repeat (half) @(negedge clk);
        sck = 1'b1;
        repeat (half) @(negedge clk);
        sck = 1'b0;
    endtask

    // Drive one frame of n bits (first bit = w[n-1]) and predict its outcome.
    task automatic send_frame(input logic [31:0] w, input int n,
                              input int half, input int gap);
        int          rc;
        bit          ok;
        logic [15:0] acc;
        repeat (gap) @(negedge clk);
        csn = 1'b0;
        sent_q.delete();
        repeat (half) @(negedge clk);
        for (int i = 0; i < n; i++) begin
            sent_q.push_back(w[n-1-i]);
            clk_bit(w[n-1-i], half);
        end
        repeat (half) @(negedge clk);
        csn = 1'b1;
        rc  = cyc;
        acc = 16'h0000;
        foreach (sent_q[i]) acc = acc * 2 + 16'(sent_q[i]);
        ok = (sent_q.size() == 16);
        if (ok) last_good = acc;
        exp_q.push_back('{ok, last_good, rc + 3});
    endtask

    task automatic collect(input int n);
        for (int i = 0; i < 60 && ev_q.size() < n; i++) @(negedge clk);
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        csn = 1'b1;
        sck = 1'b0;
        sdi = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (rx_data !== 16'h0000) begin
            errors++;
            $display("FAIL reset_data: got %h, required 0000", rx_data);
        end
        checks++;
        if (rx_valid !== 1'b0 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_strobes: got %b%b, required 00", rx_valid, frame_err);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b, required 0", busy);
        end
        @(negedge clk);
        rst = 1'b0;
        ev_q.delete();
    endtask

    // cs_n drops 3 cycles after reset release: only works if IDLE was reached.
    task automatic test_good_frame;
        ev_t a, e;
        fork
            send_frame(32'h0000A5C3, 16, 4, 3);
            begin
                repeat (8) @(negedge clk);
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL good_busy: got %b, required 1", busy);
                end
            end
        join
        collect(1);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL good_busy_end: got %b, required 0", busy);
        end
        checks++;
        if (ev_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL good_count: got %0d strobes, required %0d", ev_q.size(), exp_q.size());
        end
        while (ev_q.size() > 0 && exp_q.size() > 0) begin
            a = ev_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (a.ok !== e.ok || a.data !== e.data || a.cyc != e.cyc) begin
                errors++;
                $display("FAIL good_event: ok=%b data=%h cyc=%0d, required ok=%b data=%h cyc=%0d",
                         a.ok, a.data, a.cyc, e.ok, e.data, e.cyc);
            end
        end
        ev_q.delete();
        exp_q.delete();
    endtask

    task automatic test_bad_lengths;
        ev_t a, e;
        send_frame(32'h00005A3C, 15, 4, 4);
        send_frame(32'h0001C3A5, 17, 4, 4);
        send_frame(32'h00000000, 0, 5, 4);
        collect(3);
        checks++;
        if (ev_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL bad_count: got %0d strobes, required %0d", ev_q.size(), exp_q.size());
        end
        while (ev_q.size() > 0 && exp_q.size() > 0) begin
            a = ev_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (a.ok !== e.ok || a.data !== e.data || a.cyc != e.cyc) begin
                errors++;
                $display("FAIL bad_event: ok=%b data=%h cyc=%0d, required ok=%b data=%h cyc=%0d",
                         a.ok, a.data, a.cyc, e.ok, e.data, e.cyc);
            end
        end
        ev_q.delete();
        exp_q.delete();
    endtask

    task automatic test_back_to_back;
        ev_t a, e;
        send_frame(32'h00000000, 16, 4, 4);
        send_frame(32'h0000FFFF, 16, 4, 3);
        collect(2);
        checks++;
        if (ev_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL b2b_count: got %0d strobes, required %0d", ev_q.size(), exp_q.size());
        end
        while (ev_q.size() > 0 && exp_q.size() > 0) begin
            a = ev_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (a.ok !== e.ok || a.data !== e.data || a.cyc != e.cyc) begin
                errors++;
                $display("FAIL b2b_event: ok=%b data=%h cyc=%0d, required ok=%b data=%h cyc=%0d",
                         a.ok, a.data, a.cyc, e.ok, e.data, e.cyc);
            end
        end
        ev_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset_mid_frame;
        ev_t         a, e;
        logic [15:0] w;
        w = 16'($urandom);
        repeat (4) @(negedge clk);
        csn = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 7; i++) clk_bit(w[15-i], 4);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (rx_data !== 16'h0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_clear: data=%h busy=%b, required 0000 0", rx_data, busy);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 7; i < 16; i++) clk_bit(w[15-i], 4);
        repeat (4) @(negedge clk);
        csn = 1'b1;
        last_good = 16'h0000;
        repeat (10) @(negedge clk);
        checks++;
        if (ev_q.size() != 0) begin
            errors++;
            $display("FAIL midrst_nostrobe: got %0d strobes, required 0", ev_q.size());
        end
        ev_q.delete();
        send_frame(32'h00001234, 16, 4, 1);
        collect(1);
        checks++;
        if (ev_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL midrst_count: got %0d strobes, required %0d", ev_q.size(), exp_q.size());
        end
        while (ev_q.size() > 0 && exp_q.size() > 0) begin
            a = ev_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (a.ok !== e.ok || a.data !== e.data || a.cyc != e.cyc) begin
                errors++;
                $display("FAIL midrst_event: ok=%b data=%h cyc=%0d, required ok=%b data=%h cyc=%0d",
                         a.ok, a.data, a.cyc, e.ok, e.data, e.cyc);
            end
        end
        ev_q.delete();
        exp_q.delete();
    endtask

    task automatic test_loopback;
        ev_t a, e;
        send_frame(32'h00000000, 16, 4, 4);
        send_frame(32'h00003FF0, 16, 4, 4);
        send_frame(32'h0000FFFC, 16, 4, 4);
        collect(3);
        checks++;
        if (ev_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL loop_count: got %0d strobes, required %0d", ev_q.size(), exp_q.size());
        end
        while (ev_q.size() > 0 && exp_q.size() > 0) begin
            a = ev_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (a.ok !== e.ok || a.data !== e.data || a.cyc != e.cyc) begin
                errors++;
                $display("FAIL loop_event: ok=%b data=%h cyc=%0d, required ok=%b data=%h cyc=%0d",
                         a.ok, a.data, a.cyc, e.ok, e.data, e.cyc);
            end
        end
        ev_q.delete();
        exp_q.delete();
    endtask

    task automatic test_random;
        ev_t a, e;
        int  n, r;
        int  odd_len[5] = '{0, 1, 2, 15, 17};
        for (int k = 0; k < 24; k++) begin
            r = $urandom_range(0, 9);
            n = (r < 6) ? 16 : odd_len[$urandom_range(0, 4)];
            send_frame($urandom, n, $urandom_range(3, 6), $urandom_range(3, 6));
        end
        collect(24);
        checks++;
        if (ev_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rand_count: got %0d strobes, required %0d", ev_q.size(), exp_q.size());
        end
        while (ev_q.size() > 0 && exp_q.size() > 0) begin
            a = ev_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (a.ok !== e.ok || a.data !== e.data || a.cyc != e.cyc) begin
                errors++;
                $display("FAIL rand_event: ok=%b data=%h cyc=%0d, required ok=%b data=%h cyc=%0d",
                         a.ok, a.data, a.cyc, e.ok, e.data, e.cyc);
            end
        end
        ev_q.delete();
        exp_q.delete();
    endtask

    initial begin
        test_reset;
        test_good_frame;
        test_bad_lengths;
        test_back_to_back;
        test_reset_mid_frame;
        test_loopback;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
